// File: rtl/gate_operand_loader.sv
// Serial operand loader and result sampler for the complex_gates block.
// Shifts in x then y (MSB first), waits SETTLE cycles, then registers the gate output.
module gate_operand_loader #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             res_in,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic [7:0]       ones_cnt
);

    localparam int CNT_W = $clog2(2 * WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic [1:0]         state_q,  state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2*WIDTH-1:0] shadow_q, shadow_d;
    logic [3:0]         settle_q, settle_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               done_q, done_d;
    logic               result_q, result_d;
    logic [7:0]         ones_q, ones_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shadow_d  = shadow_q;
        settle_d  = settle_q;
        x_d       = x_q;
        y_d       = y_q;
        done_d    = 1'b0;
        result_d  = result_q;
        ones_d    = ones_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    bit_cnt_d = '0;
                    shadow_d  = '0;
                end
            end
            S_LOAD: begin
                if (ser_valid) begin
                    shadow_d  = {shadow_q[2*WIDTH-2:0], ser_in};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Operands are published together only once the final bit arrives.
                    if (bit_cnt_q == CNT_W'(2 * WIDTH - 1)) begin
                        x_d      = shadow_d[2*WIDTH-1:WIDTH];
                        y_d      = shadow_d[WIDTH-1:0];
                        settle_d = 4'(SETTLE);
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                settle_d = settle_q - 1'b1;
                if (settle_q == 4'd1) begin
                    result_d = res_in;
                    done_d   = 1'b1;
                    if (res_in && ones_q != 8'hFF) begin
                        ones_d = ones_q + 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shadow_q  <= '0;
            settle_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            done_q    <= 1'b0;
            result_q  <= 1'b0;
            ones_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shadow_q  <= shadow_d;
            settle_q  <= settle_d;
            x_q       <= x_d;
            y_q       <= y_d;
            done_q    <= done_d;
            result_q  <= result_d;
            ones_q    <= ones_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_SETTLE);
    assign done     = done_q;
    assign result   = result_q;
    assign ones_cnt = ones_q;

endmodule

// File: tb/tb_gate_operand_loader.sv
// Directed bench for gate_operand_loader; res_in comes from a small truth table
// of the operand pairs used, standing in for complex_gates.
module tb_gate_operand_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ser_in;
    logic       ser_valid;
    logic       res_in;
    logic [7:0] x;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       result;
    logic [7:0] ones_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] prev_x = '0;
    logic [7:0] prev_y = '0;
    int         exp_ones = 0;

    gate_operand_loader #(.WIDTH(8), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ser_in(ser_in),
        .ser_valid(ser_valid), .res_in(res_in), .x(x), .y(y), .busy(busy),
        .done(done), .result(result), .ones_cnt(ones_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic gate_ref(input logic [7:0] a, input logic [7:0] b);
        case ({a, b})
            16'h671B: return 1'b0;
            16'h671F: return 1'b1;
            16'hE51F: return 1'b1;
            16'hE41F: return 1'b0;
            16'hFFFF: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    assign res_in = gate_ref(x, y);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [7:0] xv, input logic [7:0] yv,
                          input bit gaps, input bit busy_start);
        logic [15:0] v;
        logic        exp_res;
        int          n;
        v = {xv, yv};
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_e0", busy, 1);
        check("done_e0", done, 0);
        for (int i = 0; i < 16; i++) begin
            if (gaps && i > 0) begin
                ser_valid = 1'b0;
                ser_in    = ~v[15-i];
                step();
            end
            ser_valid = 1'b1;
            ser_in    = v[15-i];
            start     = busy_start && (i == 5);
            step();
            start = 1'b0;
            if (i == 7 || i == 14) begin
                check("x_hold", x, prev_x);
                check("y_hold", y, prev_y);
                check("busy_load", busy, 1);
            end
        end
        ser_valid = 1'b0;
        check("x_load", x, xv);
        check("y_load", y, yv);
        check("busy_settle", busy, 1);
        check("done_early", done, 0);
        prev_x  = xv;
        prev_y  = yv;
        exp_res = gate_ref(xv, yv);
        if (exp_res && exp_ones < 255) exp_ones++;
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("settle_lat", n, 2);
        check("result", result, exp_res);
        check("ones_cnt", ones_cnt, exp_ones);
        check("busy_done", busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            start     = 1'($urandom_range(0, 1));
            ser_in    = 1'($urandom_range(0, 1));
            ser_valid = 1'($urandom_range(0, 1));
            step();
        end
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_ones", ones_cnt, 0);
        start     = 1'b0;
        ser_valid = 1'b0;
        rst_n     = 1'b1;
        step();
        check("idle_busy", busy, 0);

        run_op(8'h67, 8'h1B, 1'b0, 1'b0);
        repeat (2) step();
        run_op(8'h67, 8'h1F, 1'b1, 1'b0);
        // Starts in the done cycle of the previous operation
        run_op(8'hE5, 8'h1F, 1'b0, 1'b1);
        step();
        check("result_hold", result, 1);
        check("ones_hold", ones_cnt, 2);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ser_valid = 1'b1;
            ser_in    = 1'(i % 2);
            step();
        end
        check("midrst_x_before", x, 8'hE5);
        rst_n     = 1'b0;
        ser_valid = 1'b0;
        step();
        check("midrst_x", x, 0);
        check("midrst_y", y, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ones", ones_cnt, 0);
        rst_n    = 1'b1;
        prev_x   = '0;
        prev_y   = '0;
        exp_ones = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_done", done, 0);
        end
        run_op(8'hE4, 8'h1F, 1'b0, 1'b0);

        for (int k = 0; k < 256; k++) begin
            step();
            run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        end
        repeat (3) step();
        check("sat_final", ones_cnt, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
